// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller bundle: stage register IDs and memory status in,
// stage enables/flushes, forwarding selects and trap status out.
interface pipe_hazard_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_wr;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_reg_wr;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_valid;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mem_timeout;
    logic [31:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_wr, ex_is_load,
               mem_rd, mem_reg_wr, wb_rd, wb_reg_wr, branch_taken, dmem_req, dmem_valid,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
               fwd_a, fwd_b, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_wr, ex_is_load,
               mem_rd, mem_reg_wr, wb_rd, wb_reg_wr, branch_taken, dmem_req, dmem_valid,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
               fwd_a, fwd_b, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage RV32I pipeline, with a
// data-memory timeout trap and a stall-cycle counter.
//
// state   | meaning
// RUN     | normal issue; first frozen memory cycle is spent here
// MEMWAIT | data memory busy, pipeline frozen, wait_cnt counts frozen cycles
// ERROR   | memory never answered; pipeline held until reset
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic [31:0]    stall_cnt;

    logic freeze, load_use;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_timeout;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_wr,
                                           input logic [4:0] w_rd, input logic w_wr);
        if (m_wr && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b10;
        else if (w_wr && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign freeze   = hz.dmem_req & ~hz.dmem_valid;
    assign load_use = hz.ex_is_load & hz.ex_reg_wr & (hz.ex_rd != 5'd0) &
                      ((hz.ex_rd == hz.id_rs1) | (hz.ex_rd == hz.id_rs2));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt    = MEMWAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            MEMWAIT: begin
                if (freeze) begin
                    if (wait_cnt == WAIT_LIMIT)
                        state_nxt = ERROR;
                    else
                        wait_cnt_nxt = wait_cnt + 1'b1;
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mem_timeout = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst) begin
            // Bubble ID and EX while the rest of the pipeline is reset.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            fwd_a = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_reg_wr, hz.wb_rd, hz.wb_reg_wr);
            fwd_b = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_reg_wr, hz.wb_rd, hz.wb_reg_wr);
            if ((state == ERROR) || freeze) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_en    = 1'b0;
                ex_mem_en   = 1'b0;
                mem_wb_en   = 1'b0;
                mem_timeout = (state == ERROR);
            end else if (hz.branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_en && (state != ERROR))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.ex_mem_en   = ex_mem_en;
    assign hz.mem_wb_en   = mem_wb_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.mem_timeout = mem_timeout;
    assign hz.stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-count
// reference model of the hazard, freeze and timeout rules.
module tb_pipe_hazard_ctrl;
    localparam int TMO = 16;

    // Packed outputs: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, fwd_a, fwd_b, mem_timeout}
    localparam logic [13:0] ALL_RUN = 14'b11111_00_0000_0;
    localparam logic [13:0] RST_OUT = 14'b11111_11_0000_0;
    localparam logic [13:0] LU_OUT  = 14'b00111_01_0000_0;
    localparam logic [13:0] BR_OUT  = 14'b11111_11_0000_0;
    localparam logic [13:0] FRZ_OUT = 14'b00000_00_0000_0;
    localparam logic [13:0] ERR_OUT = 14'b00000_00_0000_1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: consecutive frozen-cycle count, trap flag, stall total.
    int          m_frz   = 0;
    bit          m_err   = 1'b0;
    logic [31:0] m_stall = '0;

    pipe_hazard_if hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    logic [13:0] outs;
    assign outs = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                   hz.if_id_flush, hz.id_ex_flush, hz.fwd_a, hz.fwd_b, hz.mem_timeout};

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.mem_reg_wr && hz.mem_rd != 0 && hz.mem_rd == rs) return 2'b10;
        if (hz.wb_reg_wr && hz.wb_rd != 0 && hz.wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        return hz.ex_is_load && hz.ex_reg_wr && hz.ex_rd != 0 &&
               (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
    endfunction

    function automatic logic [13:0] exp_outs();
        logic [3:0] f;
        if (rst) return RST_OUT;
        f = {ref_fwd(hz.ex_rs1), ref_fwd(hz.ex_rs2)};
        if (m_err)                          return {7'b0000000, f, 1'b1};
        if (hz.dmem_req && !hz.dmem_valid)  return {7'b0000000, f, 1'b0};
        if (hz.branch_taken)                return {7'b1111111, f, 1'b0};
        if (ref_lu())                       return {7'b0011101, f, 1'b0};
        return {7'b1111100, f, 1'b0};
    endfunction

    function automatic void model_edge();
        if (rst) begin
            m_frz = 0; m_err = 1'b0; m_stall = '0;
        end else if (!m_err) begin
            if (hz.dmem_req && !hz.dmem_valid) begin
                m_frz++;
                m_stall++;
                if (m_frz >= TMO) m_err = 1'b1;
            end else begin
                m_frz = 0;
                if (!hz.branch_taken && ref_lu()) m_stall++;
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0;
        hz.ex_reg_wr = 0; hz.ex_is_load = 0; hz.mem_rd = 0; hz.mem_reg_wr = 0;
        hz.wb_rd = 0; hz.wb_reg_wr = 0; hz.branch_taken = 0; hz.dmem_req = 0; hz.dmem_valid = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        hz.mem_rd = 5'd3; hz.mem_reg_wr = 1'b1; hz.ex_rs1 = 5'd3; hz.ex_rs2 = 5'd3;
        @(negedge clk);
        n_checks++;
        if (outs !== RST_OUT) $display("FAIL reset_outs got=%b exp=%b", outs, RST_OUT); else n_pass++;
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL post_reset_outs got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        n_checks++;
        if (hz.stall_cnt !== 32'd0) $display("FAIL post_reset_stall got=%0d exp=0", hz.stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.ex_is_load = 1'b1; hz.ex_reg_wr = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5;
        @(negedge clk);
        n_checks++;
        if (outs !== LU_OUT) $display("FAIL load_use_outs got=%b exp=%b", outs, LU_OUT); else n_pass++;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL load_use_release got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        n_checks++;
        if (hz.stall_cnt !== 32'd1) $display("FAIL load_use_stall got=%0d exp=1", hz.stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_branch_load_use();
        clear_inputs();
        hz.ex_is_load = 1'b1; hz.ex_reg_wr = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5;
        hz.branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== BR_OUT) $display("FAIL branch_lu_outs got=%b exp=%b", outs, BR_OUT); else n_pass++;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (hz.stall_cnt !== 32'd1) $display("FAIL branch_lu_stall got=%0d exp=1", hz.stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        hz.mem_rd = 5'd7; hz.wb_rd = 5'd7; hz.ex_rs1 = 5'd7; hz.mem_reg_wr = 1'b1; hz.wb_reg_wr = 1'b1;
        hz.ex_rs2 = 5'd9;
        @(negedge clk);
        n_checks++;
        if (hz.fwd_a !== 2'b10) $display("FAIL fwd_a_mem got=%b exp=10", hz.fwd_a); else n_pass++;
        n_checks++;
        if (hz.fwd_b !== 2'b00) $display("FAIL fwd_b_none got=%b exp=00", hz.fwd_b); else n_pass++;
        tick();
        hz.mem_reg_wr = 1'b0;
        hz.ex_rs2 = 5'd7;
        @(negedge clk);
        n_checks++;
        if (hz.fwd_a !== 2'b01) $display("FAIL fwd_a_wb got=%b exp=01", hz.fwd_a); else n_pass++;
        n_checks++;
        if (hz.fwd_b !== 2'b01) $display("FAIL fwd_b_wb got=%b exp=01", hz.fwd_b); else n_pass++;
        tick();
        hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd0;
        hz.mem_reg_wr = 1'b1; hz.wb_reg_wr = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) $display("FAIL fwd_x0 got=%b%b exp=0000", hz.fwd_a, hz.fwd_b); else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        pulse_reset();
        clear_inputs();
        hz.dmem_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== FRZ_OUT) $display("FAIL mem_wait_frozen c%0d got=%b exp=%b", i, outs, FRZ_OUT); else n_pass++;
            tick();
        end
        hz.dmem_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL mem_wait_valid got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (hz.stall_cnt !== 32'd3) $display("FAIL mem_wait_stall got=%0d exp=3", hz.stall_cnt); else n_pass++;
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL mem_wait_resume got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        pulse_reset();
        clear_inputs();
        hz.dmem_req = 1'b1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== FRZ_OUT) $display("FAIL timeout_frozen c%0d got=%b exp=%b", i, outs, FRZ_OUT); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (outs !== ERR_OUT) $display("FAIL timeout_trap got=%b exp=%b", outs, ERR_OUT); else n_pass++;
        n_checks++;
        if (hz.stall_cnt !== 32'd16) $display("FAIL timeout_stall got=%0d exp=16", hz.stall_cnt); else n_pass++;
        tick();
        hz.dmem_req = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (outs !== ERR_OUT) $display("FAIL timeout_sticky got=%b exp=%b", outs, ERR_OUT); else n_pass++;
        n_checks++;
        if (hz.stall_cnt !== 32'd16) $display("FAIL timeout_stall_hold got=%0d exp=16", hz.stall_cnt); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== RST_OUT) $display("FAIL timeout_rst_outs got=%b exp=%b", outs, RST_OUT); else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL timeout_recover got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        n_checks++;
        if (hz.stall_cnt !== 32'd0) $display("FAIL timeout_rst_stall got=%0d exp=0", hz.stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_valid_at_limit();
        pulse_reset();
        clear_inputs();
        hz.dmem_req = 1'b1;
        for (int i = 1; i < TMO; i++) tick();
        hz.dmem_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL limit_valid got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== ALL_RUN) $display("FAIL limit_no_trap got=%b exp=%b", outs, ALL_RUN); else n_pass++;
        n_checks++;
        if (hz.stall_cnt !== 32'd15) $display("FAIL limit_stall got=%0d exp=15", hz.stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) hold = ($urandom_range(0, 2) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            hz.id_rs1       = 5'($urandom_range(0, 3));
            hz.id_rs2       = 5'($urandom_range(0, 3));
            hz.ex_rs1       = 5'($urandom_range(0, 3));
            hz.ex_rs2       = 5'($urandom_range(0, 3));
            hz.ex_rd        = 5'($urandom_range(0, 3));
            hz.mem_rd       = 5'($urandom_range(0, 3));
            hz.wb_rd        = 5'($urandom_range(0, 3));
            hz.ex_reg_wr    = 1'($urandom_range(0, 1));
            hz.ex_is_load   = 1'($urandom_range(0, 1));
            hz.mem_reg_wr   = 1'($urandom_range(0, 1));
            hz.wb_reg_wr    = 1'($urandom_range(0, 1));
            hz.branch_taken = ($urandom_range(0, 5) == 0);
            if (hold) begin
                hz.dmem_req   = 1'b1;
                hz.dmem_valid = ($urandom_range(0, 24) == 0);
            end else begin
                hz.dmem_req   = ($urandom_range(0, 3) == 0);
                hz.dmem_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n_checks++;
            if (outs !== exp_outs()) $display("FAIL rand_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs()); else n_pass++;
            n_checks++;
            if (hz.stall_cnt !== m_stall) $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", c, hz.stall_cnt, m_stall); else n_pass++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_forwarding();
        test_mem_wait();
        test_timeout();
        test_valid_at_limit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
